// File: rtl/lab5_mcore_alu_arbiter.sv
// rtl/lab5_mcore_alu_arbiter.sv - round-robin arbiter sharing one ALU among NUM_REQS val/rdy requesters
// Two-stage pipeline: S1 holds granted operands, S2 holds the result until the owner accepts it.

module lab2_proc_alu (
   input  logic [31:0] in0,
   input  logic [31:0] in1,
   input  logic [3:0]  fn,
   output logic [31:0] out
);

   always_comb begin
      out = 32'd0;
      case (fn)
         4'd0:    out = in0 + in1;
         4'd1:    out = in0 - in1;
         4'd2:    out = in0 << in1[4:0];
         4'd3:    out = in0 | in1;
         4'd4:    out = {31'd0, $signed(in0) < $signed(in1)};
         4'd5:    out = {31'd0, in0 < in1};
         4'd6:    out = in0 & in1;
         4'd7:    out = in0 ^ in1;
         4'd8:    out = ~(in0 | in1);
         4'd9:    out = in0 >> in1[4:0];
         4'd10:   out = $signed(in0) >>> in1[4:0];
         4'd11:   out = {31'd0, in0 == in1};
         default: out = 32'd0;
      endcase
   end

endmodule

module lab5_mcore_alu_arbiter #(
   parameter int NUM_REQS = 4,
   parameter int IDX_W    = $clog2(NUM_REQS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQS-1:0]    req_val,
   output logic [NUM_REQS-1:0]    req_rdy,
   input  logic [NUM_REQS*68-1:0] req_msg,
   output logic [NUM_REQS-1:0]    resp_val,
   input  logic [NUM_REQS-1:0]    resp_rdy,
   output logic [31:0]            resp_msg
);

   logic             s1_val;
   logic [IDX_W-1:0] s1_id;
   logic [3:0]       s1_fn;
   logic [31:0]      s1_in0;
   logic [31:0]      s1_in1;

   logic             s2_val;
   logic [IDX_W-1:0] s2_id;
   logic [31:0]      s2_result;

   logic [IDX_W-1:0] rr_ptr;

   logic                s2_go;
   logic                s1_go;
   logic [NUM_REQS-1:0] grant;
   logic [IDX_W-1:0]    grant_id;
   logic                found;
   logic                accept;
   logic [67:0]         sel_msg;
   logic [31:0]         alu_out;

   assign s2_go = !s2_val || resp_rdy[s2_id];
   assign s1_go = !s1_val || s2_go;

   // Scan from rr_ptr upward, wrapping, and stop at the first valid requester.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      for (int k = 0; k < NUM_REQS; k++) begin
         int cand;
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQS)
            cand = cand - NUM_REQS;
         if (!found && req_val[cand]) begin
            found       = 1'b1;
            grant_id    = IDX_W'(cand);
            grant[cand] = 1'b1;
         end
      end
   end

   assign req_rdy = grant & {NUM_REQS{s1_go}};
   assign accept  = found && s1_go;
   assign sel_msg = req_msg[68*grant_id +: 68];

   lab2_proc_alu alu (
      .in0 (s1_in0),
      .in1 (s1_in1),
      .fn  (s1_fn),
      .out (alu_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_val    <= 1'b0;
         s1_id     <= '0;
         s1_fn     <= 4'd0;
         s1_in0    <= 32'd0;
         s1_in1    <= 32'd0;
         s2_val    <= 1'b0;
         s2_id     <= '0;
         s2_result <= 32'd0;
         rr_ptr    <= '0;
      end else begin
         if (accept) begin
            s1_val <= 1'b1;
            s1_id  <= grant_id;
            s1_fn  <= sel_msg[67:64];
            s1_in0 <= sel_msg[63:32];
            s1_in1 <= sel_msg[31:0];
            rr_ptr <= (grant_id == IDX_W'(NUM_REQS-1)) ? '0 : grant_id + 1'b1;
         end else if (s2_go) begin
            s1_val <= 1'b0;
         end

         if (s1_val && s2_go) begin
            s2_val    <= 1'b1;
            s2_id     <= s1_id;
            s2_result <= alu_out;
         end else if (s2_val && resp_rdy[s2_id]) begin
            s2_val <= 1'b0;
         end
      end
   end

   assign resp_val = s2_val ? (NUM_REQS'(1) << s2_id) : '0;
   assign resp_msg = s2_result;

endmodule

// File: tb/tb_lab5_mcore_alu_arbiter.sv
// tb/tb_lab5_mcore_alu_arbiter.sv - directed self-checking bench for lab5_mcore_alu_arbiter

module tb_lab5_mcore_alu_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_val;
   logic [N-1:0]   req_rdy;
   logic [N*68-1:0] req_msg;
   logic [N-1:0]   resp_val;
   logic [N-1:0]   resp_rdy;
   logic [31:0]    resp_msg;

   int n_tests = 0;
   int n_fail  = 0;

   lab5_mcore_alu_arbiter #(.NUM_REQS(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_msg  (req_msg),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .resp_msg (resp_msg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic set_msg(input int i, input logic [3:0] fn, input logic [31:0] a, input logic [31:0] b);
      req_msg[68*i +: 68] = {fn, a, b};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      req_val  = '0;
      resp_rdy = '1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      req_msg = '0;
      do_reset();

      // 1: single op and reset state
      sample();
      check("rst_req_rdy", 32'(req_rdy), 32'h0);
      check("rst_resp_val", 32'(resp_val), 32'h0);
      check("rst_resp_msg", resp_msg, 32'h0);
      tick();
      set_msg(0, 4'd0, 32'h0ffaa660, 32'h00012304);
      req_val = 4'b0001;
      sample();
      check("t1_req_rdy", 32'(req_rdy), 32'h1);
      tick();
      req_val = '0;
      sample();
      check("t1_resp_val_t1", 32'(resp_val), 32'h0);
      tick();
      sample();
      check("t1_resp_val", 32'(resp_val), 32'h1);
      check("t1_resp_msg", resp_msg, 32'h0ffbc964);
      tick();

      // 2: four-way contention from a fresh pointer
      do_reset();
      for (int i = 0; i < N; i++) set_msg(i, 4'd1, 32'h00132050, 32'hd6620040);
      for (int c = 0; c < 7; c++) begin
         req_val = (c < 5) ? '1 : '0;
         sample();
         check($sformatf("t2_req_rdy_c%0d", c), 32'(req_rdy), (c < 5) ? (32'h1 << (c % 4)) : 32'h0);
         if (c >= 2) begin
            check($sformatf("t2_resp_val_c%0d", c), 32'(resp_val), 32'h1 << ((c - 2) % 4));
            check($sformatf("t2_resp_msg_c%0d", c), resp_msg, 32'h29b12010);
         end
         tick();
      end
      req_val = '0;
      tick();

      // 3: pointer wrap from 3 back to 1
      set_msg(2, 4'd0, 32'd1, 32'd2);
      req_val = 4'b0100;
      sample();
      check("t3_grant2", 32'(req_rdy), 32'h4);
      tick();
      check("t3_rr_ptr", 32'(dut.rr_ptr), 32'd3);
      set_msg(1, 4'd0, 32'd3, 32'd4);
      set_msg(3, 4'd0, 32'd5, 32'd6);
      req_val = 4'b1010;
      sample();
      check("t3_first", 32'(req_rdy), 32'h8);
      tick();
      req_val = 4'b0010;
      sample();
      check("t3_second", 32'(req_rdy), 32'h2);
      tick();
      req_val = '0;
      tick();
      tick();
      tick();

      // 4: backpressure on requester 2
      set_msg(2, 4'd1, 32'hfff0a440, 32'h00004450);
      set_msg(1, 4'd0, 32'h0, 32'h0);
      set_msg(3, 4'd0, 32'h7, 32'h7);
      resp_rdy = 4'b1011;
      req_val  = 4'b0100;
      sample();
      check("t4_acc2", 32'(req_rdy), 32'h4);
      tick();
      req_val = 4'b0010;
      sample();
      check("t4_acc1", 32'(req_rdy), 32'h2);
      tick();
      req_val = 4'b1000;
      for (int c = 0; c < 3; c++) begin
         sample();
         check($sformatf("t4_stall_val_%0d", c), 32'(resp_val), 32'h4);
         check($sformatf("t4_stall_msg_%0d", c), resp_msg, 32'hfff05ff0);
         check($sformatf("t4_stall_rdy_%0d", c), 32'(req_rdy), 32'h0);
         tick();
      end
      req_val  = '0;
      resp_rdy = '1;
      sample();
      check("t4_drain_val", 32'(resp_val), 32'h4);
      check("t4_drain_msg", resp_msg, 32'hfff05ff0);
      tick();
      sample();
      check("t4_r1_val", 32'(resp_val), 32'h2);
      check("t4_r1_msg", resp_msg, 32'h00000000);
      tick();
      sample();
      check("t4_empty", 32'(resp_val), 32'h0);
      tick();

      // 5: reset with both stages occupied
      do_reset();
      set_msg(0, 4'd0, 32'h11, 32'h22);
      set_msg(1, 4'd0, 32'h33, 32'h44);
      resp_rdy = '0;
      req_val  = 4'b0001;
      tick();
      req_val = 4'b0010;
      tick();
      req_val = '0;
      sample();
      check("t5_full_val", 32'(resp_val), 32'h1);
      check("t5_full_msg", resp_msg, 32'h33);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sample();
      check("t5_rst_val", 32'(resp_val), 32'h0);
      check("t5_rst_rdy", 32'(req_rdy), 32'h0);
      tick();
      resp_rdy = '1;
      set_msg(0, 4'd0, 32'h5, 32'h6);
      req_val = '1;
      sample();
      check("t5_first_grant", 32'(req_rdy), 32'h1);
      tick();
      req_val = '0;
      sample();
      check("t5_no_stale", 32'(resp_val), 32'h0);
      tick();
      sample();
      check("t5_new_val", 32'(resp_val), 32'h1);
      check("t5_new_msg", resp_msg, 32'hb);
      tick();

      // 6: idle keeps pointer and outputs quiet
      for (int c = 0; c < 10; c++) begin
         sample();
         check($sformatf("t6_val_%0d", c), 32'(resp_val), 32'h0);
         check($sformatf("t6_ptr_%0d", c), 32'(dut.rr_ptr), 32'd1);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lab5_mcore_alu_arbiter.md
Name: lab5_mcore_alu_arbiter

Overview:
Shares one lab2_proc_alu instance among NUM_REQS requesters, e.g. per-core iterative units in the multicore. Each requester uses a val/rdy request interface and a val/rdy response interface. The block arbitrates round-robin, registers the operands, evaluates the ALU, and buffers the result until the owning requester accepts it. It is a 2-stage pipeline (S1 operand register, S2 result register) with full backpressure.

Parameters:
NUM_REQS, 4, number of requesters (2..8)
IDX_W, $clog2(NUM_REQS), width of requester index

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req_val  input  NUM_REQS  per-requester request valid
req_rdy  output  NUM_REQS  per-requester request ready (one-hot or zero)
req_msg  input  NUM_REQS*68  per-requester {fn[67:64], in0[63:32], in1[31:0]}; requester i at bits [68*i+67:68*i]
resp_val  output  NUM_REQS  per-requester response valid (one-hot or zero)
resp_rdy  input  NUM_REQS  per-requester response ready
resp_msg  output  32  ALU result, shared by all requesters, meaningful when any resp_val bit is set

Behaviour:
- Internal ALU: one lab2_proc_alu, driven from the S1 registers (in0, in1, fn). fn passes through uninterpreted (0=add, 1=sub, others as defined by the ALU).
- State:
  - S1: s1_val, s1_id, s1_fn, s1_in0, s1_in1.
  - S2: s2_val, s2_id, s2_result.
  - Round-robin pointer rr_ptr (IDX_W bits).
- Reset: s1_val=0, s2_val=0, rr_ptr=0. Therefore req_rdy=0, resp_val=0, and resp_msg=0 in the cycle after reset.
- Reset asserted mid-operation drops all in-flight operations; no response is produced for them.
- Stall logic:
  - s2_go = !s2_val || resp_rdy[s2_id]
  - s1_go = !s1_val || s2_go
- Arbitration:
  - Combinational round-robin over req_val, starting at rr_ptr and wrapping NUM_REQS-1 -> 0.
  - grant is one-hot, or zero if no req_val is set.
  - req_rdy = grant & {NUM_REQS{s1_go}}.
  - req_rdy[i] may depend on req_val. Requesters must not make req_val depend on req_rdy.
- Accept: when req_val[i] && req_rdy[i]:
  - S1 loads the fields of requester i, and s1_id=i.
  - rr_ptr <= (i+1) mod NUM_REQS.
  - rr_ptr is unchanged when nothing is accepted.
- S1->S2 transfer when s1_val && s2_go: s2_result <= ALU out, s2_id <= s1_id, s2_val <= 1.
- Valid bit updates:
  - s1_val <= accept ? 1 : (s2_go ? 0 : s1_val).
  - s2_val <= (s1_val && s2_go) ? 1 : ((s2_val && resp_rdy[s2_id]) ? 0 : s2_val).
- Response outputs: resp_val = s2_val ? one-hot(s2_id) : 0. resp_msg = s2_result; it holds its value while s2_val=0.
- Latency and throughput:
  - An accept in cycle t gives resp_val in cycle t+2 when there is no backpressure.
  - Throughput is 1 op/cycle, including back-to-back ops from different or the same requester.
- Simultaneous events:
  - An S2 drain and an S1->S2 transfer in the same cycle is legal.
  - An accept into S1 while S1 transfers out is legal.
- Full pipeline with resp_rdy[s2_id]=0: all req_rdy=0. S1 and S2 hold their contents stable, and resp_val/resp_msg stay stable until the handshake.
- A response is never dropped or duplicated. Responses reach each requester in that requester's accept order.
- Arithmetic is 32-bit modulo 2^32. No overflow flag.

Test Plan:
1. Single op: reset, then requester 0 sends fn=0, in0=0ffaa660, in1=00012304, with resp_rdy all 1. Required: req_rdy[0]=1 in the accept cycle; two cycles later resp_val=0001 and resp_msg=0ffbc964.
2. Contention, round-robin: all 4 requesters hold req_val=1 continuously, each sending sub 00132050-d6620040, with resp_rdy all 1. Required: grants in order 0,1,2,3,0. Each resp_msg=29b12010, and the resp_val one-hots follow the same order at 1/cycle.
3. Pointer wrap: rr_ptr=3 after a grant to 2. Requesters 1 and 3 then request together. Required: 3 is granted first, then 1.
4. Backpressure: requester 2 sends sub fff0a440-00004450 and holds resp_rdy[2]=0 for 5 cycles while requester 1 sends add 0,0.
   - Required during the stall: resp_val=0100 with resp_msg=fff05ff0 held stable; requester 1 is accepted into S1, after which all req_rdy=0.
   - Required after resp_rdy[2]=1: requester 1 gets resp_msg=00000000 one cycle after the drain.
5. Reset mid-flight: assert reset with S1 and S2 both valid. Required the next cycle: resp_val=0, req_rdy=0; the first grant after reset goes to requester 0.
6. Idle: all req_val=0 for 10 cycles. Required: resp_val=0 and rr_ptr unchanged throughout.
